// File: rtl/alu_op_sequencer_if.sv
// Board-side bundle for the ALU op sequencer: switches, five push
// buttons, and the LED result with its busy/done status.
interface alu_op_sequencer_if #(
    parameter int BITS = 16
);
    logic [BITS-1:0] SW;
    logic            BTNC;
    logic            BTNU;
    logic            BTND;
    logic            BTNL;
    logic            BTNR;
    logic [BITS-1:0] LED;
    logic            busy;
    logic            done;

    // Board / stimulus side: drives switches and buttons, observes results.
    modport master (
        output SW, BTNC, BTNU, BTND, BTNL, BTNR,
        input  LED, busy, done
    );

    // Sequencer side.
    modport slave (
        input  SW, BTNC, BTNU, BTND, BTNL, BTNR,
        output LED, busy, done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Button-driven sequencer for the switch ALU operations (leading-ones,
// ones-count, add, sub, mult). Buttons are synchronized and debounced,
// a press captures SW, and the selected op runs on a small iterative
// datapath. The result is held on LED until the next op completes.
module alu_op_sequencer #(
    parameter int BITS            = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    alu_op_sequencer_if.slave bus
);
    localparam int HALF = BITS / 2;
    localparam int NBTN = 5;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW_W = $clog2(BITS);
    localparam int MW   = $clog2(HALF);

    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [SW_W-1:0] LAST_BIT = SW_W'(BITS - 1);
    localparam logic [SW_W-1:0] LAST_MUL = SW_W'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [2:0] {OP_LO, OP_NO, OP_ADD, OP_SUB, OP_MULT} op_e;

    // Button vector, index order is also priority order (0 wins).
    logic [NBTN-1:0] btn_raw, sync1, sync2, deb, deb_q, press;
    logic [CW-1:0]   db_cnt [NBTN];

    state_e            state_q, state_d;
    op_e               op_q, ev_op;
    logic              ev_valid;
    logic [BITS-1:0]   sw_q, acc_q, acc_d, result, led_q;
    logic [SW_W-1:0]   step_q, lo_idx;
    logic              last;
    logic              busy, done;

    logic [HALF-1:0]   op_a, op_b, mag_a, mag_b;
    logic              neg;

    assign btn_raw = {bus.BTNC, bus.BTNR, bus.BTNL, bus.BTND, bus.BTNU};
    assign press   = deb & ~deb_q;

    assign op_a   = sw_q[BITS-1:HALF];
    assign op_b   = sw_q[HALF-1:0];
    assign mag_a  = op_a[HALF-1] ? -op_a : op_a;
    assign mag_b  = op_b[HALF-1] ? -op_b : op_b;
    assign neg    = op_a[HALF-1] ^ op_b[HALF-1];
    assign lo_idx = LAST_BIT - step_q;

    assign bus.LED  = led_q;
    assign bus.busy = busy;
    assign bus.done = done;

    // Synchronize buttons, count consecutive highs, register the debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is cleared by reset like any other state.
            for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its source.
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NBTN; i++) begin
                if (!sync2[i]) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= 1'b0;
                end else if (db_cnt[i] != CNT_MAX) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                    deb[i]    <= (db_cnt[i] == CNT_MAX - 1'b1);
                end
            end
        end
    end

    // Pick the single highest-priority press event of this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ev_valid = |press;
        ev_op    = OP_MULT;
        if (press[0])      ev_op = OP_LO;
        else if (press[1]) ev_op = OP_NO;
        else if (press[2]) ev_op = OP_ADD;
        else if (press[3]) ev_op = OP_SUB;
    end

    // One iteration of the selected op: next accumulator, last-cycle flag, final result.
    always_comb begin
        acc_d  = acc_q;
        last   = 1'b1;
        result = acc_q;
        case (op_q)
            OP_ADD:  result = {{HALF{op_a[HALF-1]}}, op_a} + {{HALF{op_b[HALF-1]}}, op_b};
            OP_SUB:  result = {{HALF{op_a[HALF-1]}}, op_a} - {{HALF{op_b[HALF-1]}}, op_b};
            OP_MULT: begin
                if (mag_b[step_q[MW-1:0]]) acc_d = acc_q + (BITS'(mag_a) << step_q[MW-1:0]);
                last   = (step_q == LAST_MUL);
                result = neg ? -acc_d : acc_d;
            end
            OP_LO: begin
                last   = sw_q[lo_idx] || (step_q == LAST_BIT);
                result = sw_q[lo_idx] ? BITS'(lo_idx) + 1'b1 : '0;
            end
            OP_NO: begin
                acc_d  = acc_q + BITS'(sw_q[step_q]);
                last   = (step_q == LAST_BIT);
                result = acc_d;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_IDLE:  if (ev_valid) state_d = S_RUN;
            S_RUN:   if (last)     state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture operands on an accepted event, iterate in RUN, load LED on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q   <= '0;
            op_q   <= OP_LO;
            step_q <= '0;
            acc_q  <= '0;
            led_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (ev_valid) begin
                    sw_q   <= bus.SW;
                    op_q   <= ev_op;
                    step_q <= '0;
                    acc_q  <= '0;
                end
                S_RUN: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 1'b1;
                    if (last) led_q <= result;
                end
                default: ;
            endcase
        end
    end
endmodule
